apb_master_bridge: RTL and testbench
====================================

# apb_master_bridge

Single-master APB controller that turns simple processor load/store requests into APB SETUP/ACCESS transfers and shares the bus between NUM_SLAVES peripheral slaves, for example the GPIO slave. The bridge decodes the slave index from the address, drives a one-hot PSEL, and returns the selected slave's PRDATA, PREADY and PSLVERR to the requester. It sits between the core's data-memory port and the peripheral slaves. A watchdog ends transfers that are never acknowledged.

## Interface
- NUM_SLAVES, 4, number of APB slaves (1..8)
- SEL_LSB, 12, lowest address bit of the slave index; index = cpu_addr[SEL_LSB+2:SEL_LSB]
- TIMEOUT, 16, maximum ACCESS cycles before forced termination (2..255)

Ports:
- PCLK  in  1  clock; all logic runs on the rising edge
- PRESET  in  1  reset; asynchronous and active-high
- cpu_req  in  1  request; sampled only in IDLE
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  32  byte address
- cpu_wdata  in  32  write data
- cpu_busy  out  1  high in every state except IDLE
- cpu_ready  out  1  one-cycle completion pulse
- cpu_rdata  out  32  read data, valid while cpu_ready is high
- cpu_err  out  1  error flag, valid while cpu_ready is high
- PADDR  out  32  latched address
- PWRITE  out  1  latched cpu_we
- PWDATA  out  32  latched cpu_wdata
- PSEL  out  NUM_SLAVES  one-hot slave select
- PENABLE  out  1  high in ACCESS
- PRDATA_in  in  32*NUM_SLAVES  flattened read data; slave i occupies bits [32i+31:32i]
- PREADY_in  in  NUM_SLAVES  per-slave ready
- PSLVERR_in  in  NUM_SLAVES  per-slave error

## Operation
- States: IDLE, SETUP, ACCESS, DECERR.
- **IDLE**
  - If cpu_req=1: latch cpu_addr, cpu_we and cpu_wdata into PADDR, PWRITE and PWDATA, and latch the slave index.
  - Index < NUM_SLAVES: go to SETUP. Index >= NUM_SLAVES: go to DECERR.
- **SETUP**
  - PSEL[idx]=1, PENABLE=0. Always go to ACCESS next cycle.
- **ACCESS**
  - PSEL[idx]=1, PENABLE=1. Timeout counter increments each cycle in ACCESS.
  - If PREADY_in[idx]=1: register PRDATA_in slice into cpu_rdata (forced to 0 on writes), register PSLVERR_in[idx] into cpu_err, set cpu_ready=1, go to IDLE.
  - Else if counter = TIMEOUT-1: cpu_ready=1, cpu_err=1, cpu_rdata=0, go to IDLE. PSEL and PENABLE drop in the following cycle.
- **DECERR**
  - No PSEL asserted. Next cycle: cpu_ready=1, cpu_err=1, cpu_rdata=0, go to IDLE.
- Unselected slaves' PREADY_in, PSLVERR_in and PRDATA_in are ignored.
- The timeout counter clears on entry to SETUP.
- PADDR, PWRITE and PWDATA hold their values from SETUP until the next request is accepted; they are not cleared in IDLE.
- cpu_req while busy is ignored, not queued; the requester holds it until cpu_ready.
- cpu_rdata and cpu_err hold their last values after the cpu_ready pulse.

## Timing
- Reset (asynchronous, immediate): state=IDLE, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, cpu_ready=0, cpu_err=0, cpu_rdata=0, cpu_busy=0, counter=0.
- Reset during SETUP or ACCESS aborts the transfer; no cpu_ready is produced.
- Zero-wait-state transfer: request accepted at edge 0, SETUP in cycle 1, ACCESS in cycle 2, cpu_ready high in cycle 3.
  - The bridge is already IDLE in cycle 3, so a held cpu_req starts the next transfer at that edge.
  - Peak rate is one transfer every 3 cycles.
- Each wait state adds one cycle.
- A timeout produces cpu_ready TIMEOUT+2 cycles after acceptance.
- A decode error produces cpu_ready 2 cycles after acceptance.
- PSEL is stable from SETUP through the last ACCESS cycle. PENABLE never rises without PSEL.

## Test plan
- Write 0x0000_00A5 to 0x0000_1004 with all PREADY_in=1:
  - PSEL=4'b0010 in SETUP and ACCESS, PWRITE=1, PWDATA=0xA5.
  - cpu_ready 3 cycles after acceptance, cpu_err=0, cpu_rdata=0.
- Read 0x0000_2000 with slave 2 holding PREADY low for 2 ACCESS cycles and PRDATA_in slice 2 = 0xDEAD_BEEF:
  - PENABLE high for 3 cycles.
  - cpu_ready at cycle 5 with cpu_rdata=0xDEADBEEF, cpu_err=0.
- Read slave 3 with PREADY_in[3] stuck at 0, TIMEOUT=16:
  - cpu_ready at cycle 18 with cpu_err=1, cpu_rdata=0.
  - PSEL=0 in the cycle after.
- Access 0x0000_5000 (index 5, NUM_SLAVES=4):
  - PSEL never asserted.
  - cpu_ready at cycle 2 with cpu_err=1.
- Assert PRESET mid-ACCESS:
  - PSEL, PENABLE and cpu_busy go to 0 immediately; no cpu_ready.
  - After release, a new request completes normally.
- Hold cpu_req high for two back-to-back reads, then check PSLVERR:
  - Transfers start at edges 0 and 3; each returns its own slave's data.
  - PSLVERR_in=1 on the second transfer makes cpu_err=1 on only that response.

Source files
------------

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: single-master APB controller. It converts processor
// load/store requests into APB SETUP/ACCESS transfers across NUM_SLAVES
// slaves, decodes the slave index from the address, and terminates
// unacknowledged transfers with a watchdog.
module apb_master_bridge #(
    parameter int NUM_SLAVES = 4,
    parameter int SEL_LSB    = 12,
    parameter int TIMEOUT    = 16
) (
    input  logic                     PCLK,
    input  logic                     PRESET,
    input  logic                     cpu_req,
    input  logic                     cpu_we,
    input  logic [31:0]              cpu_addr,
    input  logic [31:0]              cpu_wdata,
    output logic                     cpu_busy,
    output logic                     cpu_ready,
    output logic [31:0]              cpu_rdata,
    output logic                     cpu_err,
    output logic [31:0]              PADDR,
    output logic                     PWRITE,
    output logic [31:0]              PWDATA,
    output logic [NUM_SLAVES-1:0]    PSEL,
    output logic                     PENABLE,
    input  logic [32*NUM_SLAVES-1:0] PRDATA_in,
    input  logic [NUM_SLAVES-1:0]    PREADY_in,
    input  logic [NUM_SLAVES-1:0]    PSLVERR_in
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DECERR} state_t;

    localparam logic [3:0] SLAVE_COUNT = 4'(NUM_SLAVES);
    localparam logic [7:0] COUNT_LAST  = 8'(TIMEOUT - 1);

    state_t      state;
    state_t      state_next;
    logic [2:0]  idx;
    logic [7:0]  count;
    logic [2:0]  addr_idx;
    logic        accept;
    logic        xfer_done;
    logic        timeout_hit;
    logic        bus_active;
    logic        sel_ready;
    logic        sel_slverr;
    logic [31:0] sel_rdata;

    assign addr_idx   = cpu_addr[SEL_LSB+2:SEL_LSB];
    assign bus_active = (state == SETUP) || (state == ACCESS);
    assign PENABLE    = (state == ACCESS);
    assign cpu_busy   = (state != IDLE);

    // State register; reset is asynchronous so an in-flight transfer aborts at once.
    always_ff @(posedge PCLK or posedge PRESET) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (PRESET) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state decode plus the one-cycle event strobes used by the datapath.
    always_comb begin
        // NOTE: every output of this block gets a default first; a path that
        // leaves one unassigned would infer a latch.
        state_next  = state;
        accept      = 1'b0;
        xfer_done   = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_req) begin
                    accept     = 1'b1;
                    state_next = ({1'b0, addr_idx} < SLAVE_COUNT) ? SETUP : DECERR;
                end
            end
            SETUP:  state_next = ACCESS;
            ACCESS: begin
                // An acknowledge in the final allowed cycle wins over the watchdog.
                if (sel_ready) begin
                    xfer_done  = 1'b1;
                    state_next = IDLE;
                end else if (count == COUNT_LAST) begin
                    timeout_hit = 1'b1;
                    state_next  = IDLE;
                end
            end
            DECERR: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // One-hot select and response mux; unselected slaves never reach the requester.
    always_comb begin
        PSEL       = '0;
        sel_ready  = 1'b0;
        sel_slverr = 1'b0;
        sel_rdata  = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (idx == 3'(i)) begin
                PSEL[i]    = bus_active;
                sel_ready  = PREADY_in[i];
                sel_slverr = PSLVERR_in[i];
                sel_rdata  = PRDATA_in[32*i +: 32];
            end
        end
    end

    // Request latches, watchdog counter and registered completion response.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            PADDR     <= '0;
            PWRITE    <= 1'b0;
            PWDATA    <= '0;
            idx       <= '0;
            count     <= '0;
            cpu_ready <= 1'b0;
            cpu_err   <= 1'b0;
            cpu_rdata <= '0;
        end else begin
            cpu_ready <= 1'b0;

            if (accept) begin
                PADDR  <= cpu_addr;
                PWRITE <= cpu_we;
                PWDATA <= cpu_wdata;
                idx    <= addr_idx;
            end

            if (accept)                count <= '0;
            else if (state == ACCESS)  count <= count + 8'd1;

            if (xfer_done) begin
                cpu_ready <= 1'b1;
                cpu_err   <= sel_slverr;
                cpu_rdata <= PWRITE ? 32'd0 : sel_rdata;
            end else if (timeout_hit || (state == DECERR)) begin
                cpu_ready <= 1'b1;
                cpu_err   <= 1'b1;
                cpu_rdata <= 32'd0;
            end
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Testbench for apb_master_bridge: directed table of transfers, hand-written
// reset and back-to-back sequences, then randomized transfers checked against
// a transaction-level model of latency and response.
module tb_apb_master_bridge;

    localparam int NUM_SLAVES = 4;
    localparam int SEL_LSB    = 12;
    localparam int TIMEOUT    = 16;
    localparam int STUCK      = 1000;

    logic                     PCLK;
    logic                     PRESET;
    logic                     cpu_req;
    logic                     cpu_we;
    logic [31:0]              cpu_addr;
    logic [31:0]              cpu_wdata;
    logic                     cpu_busy;
    logic                     cpu_ready;
    logic [31:0]              cpu_rdata;
    logic                     cpu_err;
    logic [31:0]              PADDR;
    logic                     PWRITE;
    logic [31:0]              PWDATA;
    logic [NUM_SLAVES-1:0]    PSEL;
    logic                     PENABLE;
    logic [32*NUM_SLAVES-1:0] PRDATA_in;
    logic [NUM_SLAVES-1:0]    PREADY_in;
    logic [NUM_SLAVES-1:0]    PSLVERR_in;

    apb_master_bridge #(
        .NUM_SLAVES(NUM_SLAVES),
        .SEL_LSB   (SEL_LSB),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_busy  (cpu_busy),
        .cpu_ready (cpu_ready),
        .cpu_rdata (cpu_rdata),
        .cpu_err   (cpu_err),
        .PADDR     (PADDR),
        .PWRITE    (PWRITE),
        .PWDATA    (PWDATA),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PRDATA_in (PRDATA_in),
        .PREADY_in (PREADY_in),
        .PSLVERR_in(PSLVERR_in)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    // Slave models: each acknowledges after slv_wait[i] ACCESS wait cycles.
    logic [31:0] slv_data [NUM_SLAVES];
    int          slv_wait [NUM_SLAVES];
    logic        slv_err  [NUM_SLAVES];
    int          acc_cnt  [NUM_SLAVES];
    int          cyc = 0;

    for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_slv
        assign PRDATA_in[32*g +: 32] = slv_data[g];
        assign PREADY_in[g]          = (acc_cnt[g] >= slv_wait[g]);
        assign PSLVERR_in[g]         = slv_err[g];
    end

    always @(posedge PCLK) begin
        for (int i = 0; i < NUM_SLAVES; i++)
            acc_cnt[i] <= (PSEL[i] && PENABLE) ? acc_cnt[i] + 1 : 0;
        cyc <= cyc + 1;
    end

    int          n_vec = 0;
    int          n_err = 0;
    int          txn_start;
    logic [31:0] prev_rdata;
    logic        prev_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic slaves_default();
        for (int i = 0; i < NUM_SLAVES; i++) begin
            slv_data[i] = 32'hBAD0_0000 | 32'(i);
            slv_wait[i] = 0;
            slv_err[i]  = 1'b1;
        end
    endtask

    // Transaction-level model: latency in cycles from acceptance to cpu_ready,
    // the response, the slave select and the number of PENABLE cycles.
    task automatic model(input logic [31:0] addr, input logic we,
                         output int lat, output logic [31:0] rdata, output logic err,
                         output logic [NUM_SLAVES-1:0] psel, output int pen);
        int s;
        s = int'((addr >> SEL_LSB) & 32'd7);
        if (s >= NUM_SLAVES) begin
            lat = 2; rdata = 32'd0; err = 1'b1; psel = '0; pen = 0;
        end else begin
            psel = '0;
            psel[s] = 1'b1;
            if (slv_wait[s] >= TIMEOUT) begin
                lat = TIMEOUT + 2; rdata = 32'd0; err = 1'b1; pen = TIMEOUT;
            end else begin
                lat   = 3 + slv_wait[s];
                rdata = we ? 32'd0 : slv_data[s];
                err   = slv_err[s];
                pen   = slv_wait[s] + 1;
            end
        end
    endtask

    // Starts one request (called #1 after an edge with the bridge idle) and
    // follows it to cpu_ready, scrambling the request inputs while busy.
    task automatic do_txn(input string name, input logic [31:0] addr, input logic we,
                          input logic [31:0] wdata, input int exp_lat,
                          input logic [31:0] exp_rdata, input logic exp_err,
                          input logic [NUM_SLAVES-1:0] exp_psel, input int exp_pen);
        int lat, pen;
        bit seen, psel_bad, path_bad, hold_bad;
        cpu_req   = 1'b1;
        cpu_addr  = addr;
        cpu_we    = we;
        cpu_wdata = wdata;
        txn_start = cyc;
        lat = 0; pen = 0; seen = 0; psel_bad = 0; path_bad = 0; hold_bad = 0;
        while (!seen && lat < 300) begin
            tick();
            lat++;
            if (cpu_ready) begin
                seen = 1;
            end else begin
                if (PSEL !== exp_psel) psel_bad = 1;
                if (PENABLE) pen++;
                if (!cpu_busy || PADDR !== addr || PWRITE !== we || PWDATA !== wdata)
                    path_bad = 1;
                if (lat == 1 && (cpu_rdata !== prev_rdata || cpu_err !== prev_err))
                    hold_bad = 1;
                cpu_req   = 1'($urandom_range(0, 1));
                cpu_we    = 1'($urandom_range(0, 1));
                cpu_addr  = $urandom;
                cpu_wdata = $urandom;
            end
        end
        cpu_req = 1'b0;
        check({name, " ready_seen"}, 32'(seen), 32'd1);
        check({name, " latency"},    32'(lat), 32'(exp_lat));
        check({name, " rdata"},      cpu_rdata, exp_rdata);
        check({name, " err"},        32'(cpu_err), 32'(exp_err));
        check({name, " psel_ok"},    32'(psel_bad), 32'd0);
        check({name, " penable_cycles"}, 32'(pen), 32'(exp_pen));
        check({name, " latch_busy_ok"},  32'(path_bad), 32'd0);
        check({name, " resp_hold_ok"},   32'(hold_bad), 32'd0);
        check({name, " idle_at_ready"},  {27'd0, PENABLE, PSEL}, 32'd0);
        prev_rdata = exp_rdata;
        prev_err   = exp_err;
    endtask

    typedef struct {
        logic [31:0]           addr;
        logic                  we;
        logic [31:0]           wdata;
        int                    slv;
        int                    wait_st;
        logic [31:0]           sdata;
        logic                  serr;
        int                    exp_lat;
        logic [31:0]           exp_rdata;
        logic                  exp_err;
        logic [NUM_SLAVES-1:0] exp_psel;
        int                    exp_pen;
    } vec_t;

    vec_t vecs [10];

    initial begin
        int          lat, pen, s, first_start;
        logic [31:0] rd, a;
        logic        er, w, got_ready;
        logic [NUM_SLAVES-1:0] ps;

        vecs[0] = '{32'h0000_1004, 1'b1, 32'h0000_00A5, 1, 0,     32'h5555_AAAA, 1'b0, 5'd3,  32'h0,         1'b0, 4'b0010, 1};
        vecs[1] = '{32'h0000_2000, 1'b0, 32'h0,        2, 2,     32'hDEAD_BEEF, 1'b0, 5'd5,  32'hDEAD_BEEF, 1'b0, 4'b0100, 3};
        vecs[2] = '{32'h0000_3000, 1'b0, 32'h0,        3, STUCK, 32'h1234_5678, 1'b0, 5'd18, 32'h0,         1'b1, 4'b1000, 16};
        vecs[3] = '{32'h0000_5000, 1'b0, 32'h0,        -1, 0,    32'h0,         1'b0, 5'd2,  32'h0,         1'b1, 4'b0000, 0};
        vecs[4] = '{32'h0000_0010, 1'b0, 32'h0,        0, 0,     32'h1234_5678, 1'b1, 5'd3,  32'h1234_5678, 1'b1, 4'b0001, 1};
        vecs[5] = '{32'h0000_1FFC, 1'b1, 32'hCAFE_F00D, 1, 1,    32'h0BAD_0BAD, 1'b1, 5'd4,  32'h0,         1'b1, 4'b0010, 2};
        vecs[6] = '{32'h0000_3FF0, 1'b0, 32'h0,        3, 15,    32'hA5A5_5A5A, 1'b0, 5'd18, 32'hA5A5_5A5A, 1'b0, 4'b1000, 16};
        vecs[7] = '{32'hFFFF_7ABC, 1'b1, 32'h1,        -1, 0,    32'h0,         1'b0, 5'd2,  32'h0,         1'b1, 4'b0000, 0};
        vecs[8] = '{32'h0000_4000, 1'b0, 32'h0,        -1, 0,    32'h0,         1'b0, 5'd2,  32'h0,         1'b1, 4'b0000, 0};
        vecs[9] = '{32'h0000_2008, 1'b0, 32'h0,        2, 16,    32'h0000_0077, 1'b0, 5'd18, 32'h0,         1'b1, 4'b0100, 16};

        PRESET = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        prev_rdata = '0; prev_err = 1'b0;
        slaves_default();
        repeat (2) tick();
        check("reset sel_en_busy_ready", {28'd0, PSEL[0] | PSEL[1] | PSEL[2] | PSEL[3], PENABLE, cpu_busy, cpu_ready}, 32'd0);
        check("reset rdata", cpu_rdata, 32'd0);
        check("reset err_pwrite", {30'd0, cpu_err, PWRITE}, 32'd0);
        check("reset paddr", PADDR, 32'd0);
        check("reset pwdata", PWDATA, 32'd0);
        PRESET = 1'b0;
        tick();

        // Directed table.
        for (int k = 0; k < 10; k++) begin
            slaves_default();
            if (vecs[k].slv >= 0) begin
                slv_wait[vecs[k].slv] = vecs[k].wait_st;
                slv_data[vecs[k].slv] = vecs[k].sdata;
                slv_err[vecs[k].slv]  = vecs[k].serr;
            end
            do_txn($sformatf("vec%0d", k), vecs[k].addr, vecs[k].we, vecs[k].wdata,
                   vecs[k].exp_lat, vecs[k].exp_rdata, vecs[k].exp_err,
                   vecs[k].exp_psel, vecs[k].exp_pen);
        end

        // Back-to-back reads with cpu_req held; only the second reports an error.
        slaves_default();
        slv_data[0] = 32'h1111_0000; slv_err[0] = 1'b0;
        slv_data[2] = 32'h2222_0000; slv_err[2] = 1'b1;
        do_txn("b2b first", 32'h0000_0000, 1'b0, 32'h0, 3, 32'h1111_0000, 1'b0, 4'b0001, 1);
        first_start = txn_start;
        do_txn("b2b second", 32'h0000_2000, 1'b0, 32'h0, 3, 32'h2222_0000, 1'b1, 4'b0100, 1);
        check("b2b start spacing", 32'(txn_start - first_start), 32'd3);

        // Reset in the middle of ACCESS.
        slaves_default();
        slv_wait[1] = STUCK;
        cpu_req = 1'b1; cpu_addr = 32'h0000_1000; cpu_we = 1'b0;
        tick();
        cpu_req = 1'b0;
        tick();
        check("rst pre access", {27'd0, PENABLE, PSEL}, 32'h0000_0012);
        PRESET = 1'b1;
        #1;
        check("rst immediate", {26'd0, cpu_busy, PENABLE, PSEL}, 32'd0);
        got_ready = 1'b0;
        repeat (3) begin
            tick();
            if (cpu_ready) got_ready = 1'b1;
        end
        check("rst no ready", 32'(got_ready), 32'd0);
        PRESET = 1'b0;
        prev_rdata = '0; prev_err = 1'b0;
        tick();
        slv_wait[1] = 0; slv_data[1] = 32'h0F0F_1234; slv_err[1] = 1'b0;
        do_txn("after rst", 32'h0000_1000, 1'b0, 32'h0, 3, 32'h0F0F_1234, 1'b0, 4'b0010, 1);

        // Randomized transfers against the model.
        for (int n = 0; n < 60; n++) begin
            for (int i = 0; i < NUM_SLAVES; i++) begin
                case ($urandom_range(0, 7))
                    0:       slv_wait[i] = STUCK;
                    1:       slv_wait[i] = 15;
                    2:       slv_wait[i] = 16;
                    default: slv_wait[i] = int'($urandom_range(0, 4));
                endcase
                slv_data[i] = $urandom;
                slv_err[i]  = 1'($urandom_range(0, 1));
            end
            s = int'($urandom_range(0, 5));
            a = $urandom;
            a[SEL_LSB +: 3] = 3'(s);
            w = 1'($urandom_range(0, 1));
            model(a, w, lat, rd, er, ps, pen);
            do_txn($sformatf("rand%0d", n), a, w, $urandom, lat, rd, er, ps, pen);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1, "time limit");
    end

endmodule
